// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store memory master.
//   size_e         access size encoding (B/H/W/illegal)
//   access_ctrl_t  3-bit access control {zero_ext, size}
//   state_e        LSU sequencing states
//   BYTE_UNSIGNED_CTRL  control used for every byte beat of a split access
package lsu_pkg;

  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_BAD = 2'b11} size_e;

  typedef struct packed {
    logic  zero_ext;
    size_e size;
  } access_ctrl_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_SPLIT, ST_RESP} state_e;

  localparam logic [2:0] BYTE_UNSIGNED_CTRL = 3'b100;

  // Bytes are always aligned; halfwords need addr[0]=0, words addr[1:0]=00.
  function automatic logic is_aligned(input size_e sz, input logic [1:0] a);
    case (sz)
      SZ_H:    return (a[0] == 1'b0);
      SZ_W:    return (a == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  // Index of the final byte beat of a split access.
  function automatic logic [1:0] last_idx(input size_e sz);
    return (sz == SZ_W) ? 2'd3 : 2'd1;
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if: request/response handshake plus data-memory port.
//   master modport: the LSU (accepts requests, drives the memory port)
//   slave modport : the pipeline + memory side
//   Signals: req_valid_i/req_ready_o/req_write_i/req_addr_i/req_wdata_i/
//   req_access_ctrl_i, rsp_valid_o/rsp_rdata_o/rsp_err_o, mem_read_o/
//   mem_write_o/mem_addr_o/mem_wdata_o/mem_access_ctrl_o, mem_rdata_i.
interface lsu_mem_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [2:0]            req_access_ctrl_i;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  mem_read_o;
  logic                  mem_write_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [2:0]            mem_access_ctrl_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_access_ctrl_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_access_ctrl_o
  );

  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_access_ctrl_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_access_ctrl_o
  );
endinterface

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: sign/zero extends assembled load bytes to 32 bits.
//   i_bytes    assembled bytes, LSB-aligned
//   i_size     access size
//   i_zero_ext 1 = zero extend, 0 = sign extend
//   o_data     extended result (0 for illegal size)
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_bytes,
  input  size_e       i_size,
  input  logic        i_zero_ext,
  output logic [31:0] o_data
);
  always_comb begin
    o_data = '0;
    case (i_size)
      SZ_B: o_data = {{24{~i_zero_ext & i_bytes[7]}}, i_bytes[7:0]};
      SZ_H: o_data = {{16{~i_zero_ext & i_bytes[15]}}, i_bytes[15:0]};
      SZ_W: o_data = i_bytes;
      default: o_data = '0;
    endcase
  end
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator for data memory.
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset
//   bus    lsu_mem_master_if.master: request/response handshake + memory port
// Misaligned H/W accesses are broken into unsigned byte beats, so memory
// only sees aligned or byte traffic. Define LSU_MISALIGN_TRAP_EN to instead
// return an error for misaligned requests without touching memory.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  lsu_mem_master_if.master  bus
);
  state_e                r_state, w_next;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  access_ctrl_t          r_ctrl;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  access_ctrl_t          w_req_ctrl;
  logic                  w_req_bad;
  logic                  w_req_misaligned;

  assign w_req_ctrl       = access_ctrl_t'(bus.req_access_ctrl_i);
  assign w_req_bad        = (w_req_ctrl.size == SZ_BAD);
  assign w_req_misaligned = ~w_req_bad & ~is_aligned(w_req_ctrl.size, bus.req_addr_i[1:0]);

`ifndef LSU_MISALIGN_TRAP_EN
  logic [1:0]            r_idx;
  logic [DATA_WIDTH-1:0] r_asm;
  logic [DATA_WIDTH-1:0] w_asm_next;
  logic [DATA_WIDTH-1:0] w_ext;
  logic                  w_last;

  assign w_last     = (r_idx == last_idx(r_ctrl.size));
  // Assembly register is cleared on accept, so OR-ing in byte i is enough.
  assign w_asm_next = r_asm | (DATA_WIDTH'(bus.mem_rdata_i[7:0]) << {r_idx, 3'b000});

  lsu_load_extend u_ext (
    .i_bytes    (w_asm_next),
    .i_size     (r_ctrl.size),
    .i_zero_ext (r_ctrl.zero_ext),
    .o_data     (w_ext)
  );
`endif

  always_comb begin
    w_next                = r_state;
    bus.req_ready_o       = 1'b0;
    bus.rsp_valid_o       = 1'b0;
    bus.rsp_rdata_o       = '0;
    bus.rsp_err_o         = 1'b0;
    bus.mem_read_o        = 1'b0;
    bus.mem_write_o       = 1'b0;
    bus.mem_addr_o        = '0;
    bus.mem_wdata_o       = '0;
    bus.mem_access_ctrl_o = '0;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) begin
          if (w_req_bad)             w_next = ST_RESP;
`ifdef LSU_MISALIGN_TRAP_EN
          else if (w_req_misaligned) w_next = ST_RESP;
`else
          else if (w_req_misaligned) w_next = ST_SPLIT;
`endif
          else                       w_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        bus.mem_addr_o        = r_addr;
        bus.mem_access_ctrl_o = r_ctrl;
        bus.mem_write_o       = r_write;
        bus.mem_read_o        = ~r_write;
        if (r_write) bus.mem_wdata_o = r_wdata;
        w_next = ST_RESP;
      end
`ifndef LSU_MISALIGN_TRAP_EN
      ST_SPLIT: begin
        bus.mem_addr_o        = r_addr + ADDR_WIDTH'(r_idx);
        bus.mem_access_ctrl_o = BYTE_UNSIGNED_CTRL;
        bus.mem_write_o       = r_write;
        bus.mem_read_o        = ~r_write;
        if (r_write) bus.mem_wdata_o = DATA_WIDTH'(r_wdata[{r_idx, 3'b000} +: 8]);
        if (w_last) w_next = ST_RESP;
      end
`endif
      ST_RESP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_rdata_o = r_rdata;
        bus.rsp_err_o   = r_err;
        w_next          = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ctrl  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
`ifndef LSU_MISALIGN_TRAP_EN
      r_idx   <= '0;
      r_asm   <= '0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (bus.req_valid_i) begin
          r_write <= bus.req_write_i;
          r_addr  <= bus.req_addr_i;
          r_wdata <= bus.req_wdata_i;
          r_ctrl  <= w_req_ctrl;
          r_rdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
          r_err   <= w_req_bad | w_req_misaligned;
`else
          r_err   <= w_req_bad;
          r_idx   <= '0;
          r_asm   <= '0;
`endif
        end
        // Aligned loads: memory already returns extended data.
        ST_ACCESS: if (!r_write) r_rdata <= bus.mem_rdata_i;
`ifndef LSU_MISALIGN_TRAP_EN
        ST_SPLIT: begin
          r_asm <= w_asm_next;
          r_idx <= r_idx + 2'd1;
          if (w_last && !r_write) r_rdata <= w_ext;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a small byte-addressed memory model.
module tb_lsu_mem_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  lsu_mem_master_if bus ();
  lsu_mem_master dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  // Memory model: 512 bytes, address folded to {a[16], a[7:0]}.
  logic [7:0]  mem_b [0:511] = '{default: 8'h00};
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [2:0]  wr_ctrl_q[$];
  int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0;

  function automatic logic [8:0] idx(input logic [31:0] a);
    return {a[16], a[7:0]};
  endfunction

  always_comb begin
    logic [31:0] a;
    logic [7:0]  b;
    logic [15:0] h;
    a = bus.mem_addr_o;
    bus.mem_rdata_i = '0;
    case (bus.mem_access_ctrl_o[1:0])
      2'b00: begin
        b = mem_b[idx(a)];
        bus.mem_rdata_i = bus.mem_access_ctrl_o[2] ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'b01: begin
        h = {mem_b[idx(a + 1)], mem_b[idx(a)]};
        bus.mem_rdata_i = bus.mem_access_ctrl_o[2] ? {16'h0, h} : {{16{h[15]}}, h};
      end
      2'b10: bus.mem_rdata_i = {mem_b[idx(a + 3)], mem_b[idx(a + 2)], mem_b[idx(a + 1)], mem_b[idx(a)]};
      default: bus.mem_rdata_i = '0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.mem_write_o) begin
      mem_b[idx(bus.mem_addr_o)] <= bus.mem_wdata_o[7:0];
      if (bus.mem_access_ctrl_o[1:0] != 2'b00) mem_b[idx(bus.mem_addr_o + 1)] <= bus.mem_wdata_o[15:8];
      if (bus.mem_access_ctrl_o[1:0] == 2'b10) begin
        mem_b[idx(bus.mem_addr_o + 2)] <= bus.mem_wdata_o[23:16];
        mem_b[idx(bus.mem_addr_o + 3)] <= bus.mem_wdata_o[31:24];
      end
      wr_addr_q.push_back(bus.mem_addr_o);
      wr_data_q.push_back(bus.mem_wdata_o);
      wr_ctrl_q.push_back(bus.mem_access_ctrl_o);
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.mem_read_o) rd_cnt <= rd_cnt + 1;
    if (bus.mem_read_o && bus.mem_write_o) both_cnt <= both_cnt + 1;
  end

  // Issues one request and waits (bounded) for its response.
  // lat = cycles from the handshake edge to the response cycle, -1 on timeout.
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] c, output int lat, output logic [31:0] rd,
                        output logic er);
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_write_i = wr; bus.req_addr_i = a;
    bus.req_wdata_i = d; bus.req_access_ctrl_i = c;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    lat = -1; rd = '0; er = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.rsp_valid_o) begin
        lat = k; rd = bus.rsp_rdata_o; er = bus.rsp_err_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready_o); end
    checks++; if ({bus.mem_read_o, bus.mem_write_o, bus.rsp_valid_o, bus.rsp_err_o} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 0000", {bus.mem_read_o, bus.mem_write_o, bus.rsp_valid_o, bus.rsp_err_o}); end
    checks++; if ({bus.mem_addr_o, bus.mem_wdata_o, bus.mem_access_ctrl_o, bus.rsp_rdata_o} !== '0) begin
      errors++; $display("FAIL reset_buses: mem_addr %h wdata %h ctrl %b rdata %h want 0", bus.mem_addr_o, bus.mem_wdata_o, bus.mem_access_ctrl_o, bus.rsp_rdata_o); end
    rst = 1'b0;
  endtask

  task automatic test_aligned_word();
    int lat; logic [31:0] rd; logic er; int w0;
    w0 = wr_cnt;
    do_req(1'b1, 32'h0001_0000, 32'hDEAD_BEEF, 3'b010, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL sw_write_pulses: got %0d want 1", wr_cnt - w0); end
    checks++; if ({er, rd} !== 33'h0) begin errors++; $display("FAIL sw_rsp: err %b rdata %h want 0/0", er, rd); end
    do_req(1'b0, 32'h0001_0000, 32'h0, 3'b010, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_loads();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b0, 32'h0001_0003, 32'h0, 3'b000, lat, rd, er);
    checks++; if (rd !== 32'hFFFF_FFDE) begin errors++; $display("FAIL lb_sext: got %h want ffffffde", rd); end
    do_req(1'b0, 32'h0001_0003, 32'h0, 3'b100, lat, rd, er);
    checks++; if (rd !== 32'h0000_00DE) begin errors++; $display("FAIL lbu_zext: got %h want 000000de", rd); end
  endtask

  task automatic test_aligned_half();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 32'h0001_0010, 32'h5555_9876, 3'b001, lat, rd, er);
    do_req(1'b0, 32'h0001_0010, 32'h0, 3'b001, lat, rd, er);
    checks++; if (rd !== 32'hFFFF_9876) begin errors++; $display("FAIL lh_aligned: got %h want ffff9876", rd); end
    do_req(1'b0, 32'h0001_0010, 32'h0, 3'b101, lat, rd, er);
    checks++; if (rd !== 32'h0000_9876) begin errors++; $display("FAIL lhu_aligned: got %h want 00009876", rd); end
  endtask

  task automatic test_split_store();
    int lat; logic [31:0] rd; logic er; int w0;
    logic [31:0] exp_a [4];
    logic [7:0]  exp_d [4];
    exp_a = '{32'h0001_0001, 32'h0001_0002, 32'h0001_0003, 32'h0001_0004};
    exp_d = '{8'h44, 8'h33, 8'h22, 8'h11};
    w0 = wr_cnt;
    do_req(1'b1, 32'h0001_0001, 32'h1122_3344, 3'b010, lat, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if ({lat, er} !== {32'd1, 1'b1}) begin errors++; $display("FAIL trap_sw: lat %0d err %b want 1/1", lat, er); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL trap_sw_writes: got %0d want 0", wr_cnt - w0); end
`else
    checks++; if (lat !== 5) begin errors++; $display("FAIL split_sw_latency: got %0d want 5", lat); end
    checks++; if (wr_cnt - w0 !== 4) begin errors++; $display("FAIL split_sw_writes: got %0d want 4", wr_cnt - w0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({wr_addr_q[w0+i], wr_data_q[w0+i], wr_ctrl_q[w0+i]} !== {exp_a[i], 24'h0, exp_d[i], 3'b100}) begin
        errors++; $display("FAIL split_sw_beat%0d: addr %h data %h ctrl %b want %h %h 100", i,
                           wr_addr_q[w0+i], wr_data_q[w0+i], wr_ctrl_q[w0+i], exp_a[i], exp_d[i]);
      end
    end
    do_req(1'b0, 32'h0001_0004, 32'h0, 3'b010, lat, rd, er);
    checks++; if (rd !== 32'h0000_0011) begin errors++; $display("FAIL lw_after_split: got %h want 00000011", rd); end
`endif
  endtask

  task automatic test_split_load();
    int lat; logic [31:0] rd; logic er; int r0;
    do_req(1'b1, 32'h0001_0001, 32'h0000_0080, 3'b000, lat, rd, er);
    do_req(1'b1, 32'h0001_0002, 32'h0000_00FF, 3'b000, lat, rd, er);
    r0 = rd_cnt;
    do_req(1'b0, 32'h0001_0001, 32'h0, 3'b001, lat, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if ({lat, er, rd} !== {32'd1, 1'b1, 32'h0}) begin errors++; $display("FAIL trap_lh: lat %0d err %b rdata %h want 1/1/0", lat, er, rd); end
    checks++; if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL trap_lh_reads: got %0d want 0", rd_cnt - r0); end
`else
    checks++; if ({lat, er, rd} !== {32'd3, 1'b0, 32'hFFFF_FF80}) begin errors++; $display("FAIL split_lh: lat %0d err %b rdata %h want 3/0/ffffff80", lat, er, rd); end
    checks++; if (rd_cnt - r0 !== 2) begin errors++; $display("FAIL split_lh_reads: got %0d want 2", rd_cnt - r0); end
    do_req(1'b0, 32'h0001_0001, 32'h0, 3'b101, lat, rd, er);
    checks++; if (rd !== 32'h0000_FF80) begin errors++; $display("FAIL split_lhu: got %h want 0000ff80", rd); end
`endif
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] rd; logic er; int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    do_req(1'b0, 32'h0001_0000, 32'h0, 3'b011, lat, rd, er);
    checks++; if ({lat, er, rd} !== {32'd1, 1'b1, 32'h0}) begin errors++; $display("FAIL illegal_ld: lat %0d err %b rdata %h want 1/1/0", lat, er, rd); end
    do_req(1'b1, 32'h0001_0000, 32'hFFFF_FFFF, 3'b111, lat, rd, er);
    checks++; if ({lat, er, rd} !== {32'd1, 1'b1, 32'h0}) begin errors++; $display("FAIL illegal_st: lat %0d err %b rdata %h want 1/1/0", lat, er, rd); end
    checks++; if ((wr_cnt - w0) + (rd_cnt - r0) !== 0) begin errors++; $display("FAIL illegal_strobes: got %0d want 0", (wr_cnt - w0) + (rd_cnt - r0)); end
  endtask

  task automatic test_wrap();
`ifndef LSU_MISALIGN_TRAP_EN
    int lat; logic [31:0] rd; logic er; int w0;
    logic [31:0] exp_a [4];
    exp_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    w0 = wr_cnt;
    do_req(1'b1, 32'hFFFF_FFFE, 32'h0102_0304, 3'b010, lat, rd, er);
    checks++; if (wr_cnt - w0 !== 4) begin errors++; $display("FAIL wrap_writes: got %0d want 4", wr_cnt - w0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr_q[w0+i] !== exp_a[i]) begin
        errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, wr_addr_q[w0+i], exp_a[i]);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
`ifndef LSU_MISALIGN_TRAP_EN
    int w0; int seen;
    w0 = wr_cnt; seen = 0;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_write_i = 1'b1; bus.req_addr_i = 32'h0001_0021;
    bus.req_wdata_i = 32'hAABB_CCDD; bus.req_access_ctrl_i = 3'b010;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.mem_read_o, bus.mem_write_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_access_ctrl_o} !== '0) begin
      errors++; $display("FAIL rst_mid_mem: rd %b wr %b addr %h wdata %h ctrl %b want all 0", bus.mem_read_o,
                         bus.mem_write_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_access_ctrl_o); end
    checks++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL rst_mid_bytes: got %0d want 2", wr_cnt - w0); end
    checks++; if ({mem_b[idx(32'h0001_0021)], mem_b[idx(32'h0001_0022)], mem_b[idx(32'h0001_0023)]} !== 24'hDDCC00) begin
      errors++; $display("FAIL rst_mid_mem_content: got %h want ddcc00", {mem_b[idx(32'h0001_0021)], mem_b[idx(32'h0001_0022)], mem_b[idx(32'h0001_0023)]}); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.rsp_valid_o) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_rsp: got %0d responses want 0", seen); end
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", bus.req_ready_o); end
    checks++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL rst_mid_no_more_writes: got %0d want 2", wr_cnt - w0); end
`endif
  endtask

  initial begin
    bus.req_valid_i = 1'b0; bus.req_write_i = 1'b0; bus.req_addr_i = '0;
    bus.req_wdata_i = '0; bus.req_access_ctrl_i = '0;
    test_reset();
    test_aligned_word();
    test_byte_loads();
    test_aligned_half();
    test_split_store();
    test_split_load();
    test_illegal();
    test_wrap();
    test_reset_mid();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL rd_wr_exclusive: got %0d overlaps want 0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, want finish");
    $fatal(1);
  end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the data-memory port (read/write strobes, address, write data, 3-bit access control) and consumes its combinational read data.
- Sits between the MEM pipeline stage and data memory; accepts one request at a time over a valid/ready handshake and returns a one-cycle response pulse.
- Splits misaligned halfword/word accesses into sequential byte accesses, so data memory only ever sees aligned or byte traffic.

Parameters:
- ADDR_WIDTH, 32, width of request and memory addresses.
- DATA_WIDTH, 32, data width; fixed at 32, with other values unsupported.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  LSU can accept a request (state IDLE).
- req_write_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, LSB-aligned.
- req_access_ctrl_i  in  3  [1:0] size (00 B, 01 H, 10 W, 11 illegal); [2] zero-extend for loads.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  illegal size, or misaligned access when trapping is enabled.
- mem_read_o  out  1  memory read strobe.
- mem_write_o  out  1  memory write strobe.
- mem_addr_o  out  32  memory byte address.
- mem_wdata_o  out  32  memory write data.
- mem_access_ctrl_o  out  3  memory access control, same encoding as the request.
- mem_rdata_i  in  32  memory read data, combinational with the address.

Behaviour:
- Reset:
  - State returns to IDLE.
  - All mem_* outputs, rsp_valid_o, rsp_rdata_o and rsp_err_o are 0; req_ready_o is 1.
  - Reset asserted mid-operation aborts immediately. Bytes already written by a split store stay written; no response is produced.
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE:
  - req_ready_o = 1. On req_valid_i, latch write flag, address, wdata and access control into request registers, and clear the byte index and assembly register.
  - Next state:
    - size 11 → RESP with err = 1.
    - aligned (B; H with addr[0] = 0; W with addr[1:0] = 00) → ACCESS.
    - otherwise → SPLIT.
- ACCESS (one cycle):
  - Drive mem_addr_o = latched address and mem_access_ctrl_o = latched control.
  - Store: mem_write_o = 1 and mem_wdata_o = latched wdata.
  - Load: mem_read_o = 1; capture mem_rdata_i into the result register.
  - Next state: RESP.
- SPLIT (N cycles; N = 2 for H, 4 for W; index i = 0..N-1):
  - mem_addr_o = addr + i, wrapping mod 2^32. mem_access_ctrl_o = 3'b100 (unsigned byte).
  - Store: mem_write_o = 1, mem_wdata_o[7:0] = wdata[8i+7:8i], upper bits 0.
  - Load: mem_read_o = 1, mem_rdata_i[7:0] → assembly byte i.
  - After i = N-1 → RESP.
  - Load extension per the original zero-extend bit is applied on entry to RESP.
- RESP (one cycle):
  - rsp_valid_o = 1 with rsp_rdata_o/rsp_err_o. Loads already returned extended data from memory when aligned.
  - Next state: IDLE. req_ready_o = 0 in this cycle.
- mem_read_o and mem_write_o are never both 1. Memory strobes are 0 outside ACCESS/SPLIT.
- Latency from handshake to rsp_valid_o:
  - aligned: 2 cycles.
  - split H: 3 cycles.
  - split W: 5 cycles.
  - illegal: 1 cycle.
- No response backpressure; the pipeline stalls on req_ready_o.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned H/W requests go IDLE → RESP with rsp_err_o = 1.
  - No memory strobe is issued; SPLIT logic is not compiled.
- Undefined: misaligned requests are split as described above.

Decomposition:
- lsu_pkg holds:
  - size_e (SZ_B, SZ_H, SZ_W, SZ_BAD).
  - access_ctrl_t packed struct {zero_ext, size}.
  - state_e.
  - BYTE_UNSIGNED_CTRL constant = 3'b100.
- One combinational sub-module, lsu_load_extend: takes assembled bytes, size and zero-extend, and produces the 32-bit result.

Test Plan:
- Aligned SW 0x10000 ← 0xDEADBEEF, then LW 0x10000 → rsp_rdata_o = 0xDEADBEEF. Each response arrives 2 cycles after its handshake; one mem_write_o pulse.
- LB 0x10003 holding 0xDE → 0xFFFFFFDE. LBU at the same address → 0x000000DE.
- Misaligned SW 0x10001 ← 0x11223344 → four byte writes at 0x10001..0x10004 (44, 33, 22, 11). Following aligned LW 0x10004 → byte0 = 0x11. rsp_valid_o 5 cycles after the handshake.
- Misaligned LH 0x10001 over bytes 0x80, 0xFF → 0xFFFFFF80 in 3 cycles. With LSU_MISALIGN_TRAP_EN: rsp_err_o = 1 in 1 cycle, no strobes.
- Size 11 request → rsp_err_o = 1, rsp_rdata_o = 0, no mem strobe. Split SW at 0xFFFFFFFE → addresses wrap to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- rst_i asserted during the third SPLIT cycle → all mem_* outputs 0 immediately, no rsp_valid_o, req_ready_o = 1 after reset releases.
